palette_loader: RTL
===================

Name: palette_loader

Overview:
- Sits directly downstream of the ROM-image decoder.
- Consumes the decoder's `palette` window strobe and the raw ioctl byte stream, then packs consecutive byte triples into RGB888 entries.
- Writes the entries into an internal 256x24 palette RAM.
- The video/LCD compositor reads the RAM through a synchronous port; the block also reports load completion and error status.

Parameters:
- ENTRIES, 256, number of palette entries; must be a power of two, max 256.
- ADDR_W, 8, log2(ENTRIES).

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- ioctl_download  in  1  download in progress
- ioctl_addr  in  25  download byte address
- ioctl_dout  in  8  download byte
- palette  in  1  palette window from the decoder
- rd_addr  in  ADDR_W  compositor read index
- rd_data  out  24  {R,G,B} at rd_addr, 1-cycle latency
- loading  out  1  palette load in progress (compositor forces blank)
- pal_valid  out  1  full palette loaded without error
- err_short  out  1  window closed before ENTRIES complete triples
- err_over  out  1  bytes arrived beyond ENTRIES*3
- entry_cnt  out  ADDR_W+1  entries written, 0..ENTRIES

Behaviour:
- Reset values:
  - All outputs 0 except rd_data, which is undefined until the first read.
  - State IDLE; phase 0; index 0.
  - RAM contents are not cleared.
- Byte strobe: `byte_stb` = (ioctl_addr != registered previous ioctl_addr). The previous address is registered every cycle and resets to 0.
- Accept rule: a byte is accepted when byte_stb && palette && state==LOAD. The accepted byte is ioctl_dout in that same cycle.
- States:
  - IDLE:
    - Rising ioctl_download → ARM.
    - On entry to ARM, clear pal_valid, err_short, err_over, entry_cnt, phase and index.
  - ARM:
    - palette high → LOAD.
    - The byte present on the transition cycle is accepted if byte_stb.
    - Falling ioctl_download while in ARM → IDLE; no flags set.
  - LOAD:
    - Phase 0 latches R, phase 1 latches G.
    - Phase 2 writes {R,G,dout} to RAM[index] in the next cycle (1-cycle write pipeline), then increments index and entry_cnt.
    - Phase wraps 2→0.
  - LOAD exit conditions:
    - palette low → DONE.
    - Falling ioctl_download → DONE.
  - DONE:
    - Evaluate flags, then → IDLE.
    - pal_valid = (entry_cnt==ENTRIES) && !err_short && !err_over.
- loading = 1 in ARM and LOAD, and also in DONE.
- Boundary conditions:
  - Overflow: once entry_cnt==ENTRIES, further accepted bytes are dropped and err_over is set. The RAM is not written.
  - Short window: leaving LOAD with phase!=0 or entry_cnt<ENTRIES sets err_short. A partial triple is discarded, never written.
  - Rising ioctl_download while in LOAD restarts at ARM with all counters and flags cleared. Entries already written remain in RAM.
  - Reset mid-load: immediate return to IDLE, flags cleared. RAM holds a partial image and pal_valid stays 0.
- Read port:
  - rd_data is registered; RAM[rd_addr] appears on the cycle after rd_addr is presented.
  - A read and write to the same address in the same cycle returns the old data.
- Widths: entry_cnt saturates at ENTRIES; index wraps modulo ENTRIES but is gated by the overflow rule.

Optional Feature:
- Macro: PAL_CHECKSUM_EN.
- When defined:
  - Adds output pal_sum (16 bits), a modulo-2^16 sum of every accepted byte, including dropped overflow bytes.
  - The sum is cleared on entry to ARM.
  - Adds output pal_sum_vld, which pulses for 1 cycle in DONE.
- When undefined: neither port nor the adder exists; behaviour is otherwise identical.

Decomposition:
- Shared package gnw_pal_pkg holds:
  - Constants PAL_ENTRIES=256, PAL_BYTES_PER_ENTRY=3.
  - Typedef rgb888_t {r,g,b: 8 bits each}.
  - State enum pal_state_t {IDLE, ARM, LOAD, DONE}.
- Sub-module pal_ram: simple dual-port ENTRIES x 24 RAM, one write port and one registered read port, inferrable as block RAM.

Test Plan:
- Nominal load:
  - Stimulus: download rises; palette high; 768 bytes with byte i = i mod 256, one address step per 2 cycles; then palette low.
  - Required: entry_cnt=256, pal_valid=1, no errors; rd_addr=5 → rd_data=0x0F1011 one cycle later.
- Short window:
  - Stimulus: palette drops after 100 bytes.
  - Required: entry_cnt=33, err_short=1, pal_valid=0; RAM[33] unchanged.
- Overflow:
  - Stimulus: 771 bytes inside the window.
  - Required: entry_cnt=256, err_over=1, pal_valid=0; RAM[0] not overwritten.
- Stalled address:
  - Stimulus: ioctl_addr held for 10 cycles with palette high.
  - Required: exactly one byte accepted.
- Restart:
  - Stimulus: second download rise at entry 40.
  - Required: counters reset; the next full load gives pal_valid=1.
  - Stimulus: rst_n low mid-load.
  - Required: all flags 0 asynchronously.
- PAL_CHECKSUM_EN:
  - Stimulus: nominal load of 768 bytes with byte i = i mod 256.
  - Required: pal_sum=0x17E80 mod 2^16=0x7E80, with a single pal_sum_vld pulse.

Source files
------------

// File: rtl/gnw_pal_pkg.sv
// Shared palette-loader types: entry layout, FSM states and sizing constants.
package gnw_pal_pkg;

  localparam int unsigned PAL_ENTRIES         = 256;
  localparam int unsigned PAL_BYTES_PER_ENTRY = 3;
  localparam int unsigned PAL_RGB_W           = 24;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    LOAD = 2'd2,
    DONE = 2'd3
  } pal_state_t;

endpackage

// File: rtl/pal_ram.sv
// Simple dual-port palette RAM: one write port, one registered read port.
// Read-during-write to the same address returns the previous contents.
module pal_ram
  import gnw_pal_pkg::*;
#(
  parameter int unsigned ENTRIES = PAL_ENTRIES,
  parameter int unsigned ADDR_W  = 8
) (
  input  logic                 clk_sys,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    waddr,
  input  rgb888_t              wdata,
  input  logic [ADDR_W-1:0]    raddr,
  output logic [PAL_RGB_W-1:0] rdata
);

  rgb888_t mem [ENTRIES];

  // No reset: contents survive reset and the array maps onto block RAM.
  always_ff @(posedge clk_sys) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/palette_loader.sv
// Packs the decoder's palette byte window into RGB888 entries and serves them
// to the compositor. Optional macro PAL_CHECKSUM_EN adds pal_sum/pal_sum_vld.
module palette_loader
  import gnw_pal_pkg::*;
#(
  parameter int unsigned ENTRIES = PAL_ENTRIES,
  parameter int unsigned ADDR_W  = 8
) (
  input  logic                 clk_sys,
  input  logic                 rst_n,
  input  logic                 ioctl_download,
  input  logic [24:0]          ioctl_addr,
  input  logic [7:0]           ioctl_dout,
  input  logic                 palette,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [PAL_RGB_W-1:0] rd_data,
  output logic                 loading,
  output logic                 pal_valid,
  output logic                 err_short,
  output logic                 err_over,
  output logic [ADDR_W:0]      entry_cnt
`ifdef PAL_CHECKSUM_EN
  ,
  output logic [15:0]          pal_sum,
  output logic                 pal_sum_vld
`endif
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned SUM_W  = 16;
  localparam logic [CNT_W-1:0] FULL    = CNT_W'(ENTRIES);
  localparam logic [1:0]       PH_R    = 2'd0;
  localparam logic [1:0]       PH_G    = 2'd1;
  localparam logic [1:0]       PH_LAST = 2'(PAL_BYTES_PER_ENTRY - 1);

  pal_state_t state, state_nxt;

  logic [24:0]       prev_addr;
  logic              dl_q;
  logic              byte_stb_c;
  logic              dl_rise_c;
  logic              dl_fall_c;
  logic              enter_arm_c;
  logic              accept_c;
  logic              eval_c;
  logic              short_c;

  logic [1:0]        phase;
  logic [ADDR_W-1:0] index;
  logic [7:0]        r_q;
  logic [7:0]        g_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  rgb888_t           wr_data_q;

  assign byte_stb_c = (ioctl_addr != prev_addr);
  assign dl_rise_c  = ioctl_download & ~dl_q;
  assign dl_fall_c  = ~ioctl_download & dl_q;
  assign short_c    = (phase != PH_R) || (entry_cnt < FULL);

  // State register.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-cycle datapath strobes.
  always_comb begin
    state_nxt   = state;
    enter_arm_c = 1'b0;
    accept_c    = 1'b0;
    eval_c      = 1'b0;
    case (state)
      IDLE: begin
        if (dl_rise_c) begin
          state_nxt   = ARM;
          enter_arm_c = 1'b1;
        end
      end
      ARM: begin
        if (dl_fall_c) begin
          state_nxt = IDLE;
        end else if (palette) begin
          state_nxt = LOAD;
          accept_c  = byte_stb_c;
        end
      end
      LOAD: begin
        if (dl_rise_c) begin
          state_nxt   = ARM;
          enter_arm_c = 1'b1;
        end else begin
          accept_c = byte_stb_c && palette;
          if (!palette || dl_fall_c) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        // A download that drops and re-rises across the window end restarts here.
        if (dl_rise_c) begin
          state_nxt   = ARM;
          enter_arm_c = 1'b1;
        end else begin
          state_nxt = IDLE;
          eval_c    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Byte packing, write pipeline, counters and status flags.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      prev_addr <= '0;
      dl_q      <= 1'b0;
      loading   <= 1'b0;
      pal_valid <= 1'b0;
      err_short <= 1'b0;
      err_over  <= 1'b0;
      entry_cnt <= '0;
      phase     <= PH_R;
      index     <= '0;
      r_q       <= '0;
      g_q       <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      prev_addr <= ioctl_addr;
      dl_q      <= ioctl_download;
      loading   <= (state_nxt != IDLE);
      wr_en_q   <= 1'b0;
      if (enter_arm_c) begin
        pal_valid <= 1'b0;
        err_short <= 1'b0;
        err_over  <= 1'b0;
        entry_cnt <= '0;
        phase     <= PH_R;
        index     <= '0;
      end else begin
        if (accept_c) begin
          if (entry_cnt == FULL) begin
            err_over <= 1'b1;
          end else if (phase == PH_LAST) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= index;
            wr_data_q <= '{r: r_q, g: g_q, b: ioctl_dout};
            index     <= index + ADDR_W'(1);
            entry_cnt <= entry_cnt + CNT_W'(1);
            phase     <= PH_R;
          end else if (phase == PH_R) begin
            r_q   <= ioctl_dout;
            phase <= PH_G;
          end else begin
            g_q   <= ioctl_dout;
            phase <= PH_LAST;
          end
        end
        if (eval_c) begin
          err_short <= short_c;
          pal_valid <= (entry_cnt == FULL) && !short_c && !err_over;
        end
      end
    end
  end

`ifdef PAL_CHECKSUM_EN
  // Running byte sum over the window, overflow bytes included.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      pal_sum     <= '0;
      pal_sum_vld <= 1'b0;
    end else begin
      pal_sum_vld <= (state_nxt == DONE);
      if (enter_arm_c) begin
        pal_sum <= '0;
      end else if (accept_c) begin
        pal_sum <= pal_sum + SUM_W'(ioctl_dout);
      end
    end
  end
`endif

  pal_ram #(
    .ENTRIES (ENTRIES),
    .ADDR_W  (ADDR_W)
  ) u_pal_ram (
    .clk_sys (clk_sys),
    .we      (wr_en_q),
    .waddr   (wr_addr_q),
    .wdata   (wr_data_q),
    .raddr   (rd_addr),
    .rdata   (rd_data)
  );

endmodule
